platform_scan_scheduler: RTL and testbench

Sequential collision scheduler for the Doodle Jump datapath. Once per frame it walks the platform table through a single read port, one slot per cycle, instead of comparing all platforms in parallel. It tracks the platform the doodle is standing on (the "ground") and issues the landing decision used by the jump/physics logic. It sits between the platform table memory and the doodle motion controller.

---
 rtl/platform_scan_scheduler.sv | 178 +++++++++++++++++
 tb/tb_platform_scan_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_scan_scheduler.sv
// Per-frame platform collision scheduler: walks the platform table one slot per cycle,
// keeps the highest-index landing match as the new ground and resolves the landing decision.
module platform_scan_scheduler #(
  parameter int N_PLATFORMS = 93,
  parameter int DOODLE_H    = 80,
  parameter int HIT_DEPTH   = 30,
  parameter int X_LEFT      = 61,
  parameter int X_RIGHT     = 80,
  parameter int FLOOR_Y     = 767
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [10:0] doodle_x,
  input  logic [9:0]  doodle_y,
  input  logic        doodle_fall_direction,
  output logic        plat_rd,
  output logic [6:0]  plat_addr,
  input  logic [21:0] plat_data,
  input  logic        plat_active,
  output logic        busy,
  output logic        done,
  output logic        doodle_collision,
  output logic [9:0]  ground_y,
  output logic [10:0] ground_x
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    DRAIN   = 2'd2,
    RESOLVE = 2'd3
  } state_t;

  localparam logic signed [12:0] H_C     = 13'(DOODLE_H);
  localparam logic signed [12:0] DEPTH_C = 13'(HIT_DEPTH);
  localparam logic signed [12:0] XL_C    = 13'(X_LEFT);
  localparam logic signed [12:0] XR_C    = 13'(X_RIGHT);
  localparam logic signed [12:0] FLOOR_C = 13'(FLOOR_Y);
  localparam logic [6:0]         LAST_C  = 7'(N_PLATFORMS - 1);

  state_t      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic        rd_q, busy_q, done_q, coll_q;
  logic [9:0]  gy_q;
  logic [10:0] gx_q;
  logic [10:0] dx_q;
  logic [9:0]  dy_q;
  logic        fall_q;
  logic        cap_vld_q, cap_act_q;
  logic [10:0] cap_x_q, cap_y_q;
  logic        pend_vld_q;
  logic [10:0] pend_x_q, pend_y_q;

  logic signed [12:0] dx13_s, feet13_s, px13_s, py13_s, gx13_s, gy13_s;
  logic        match_s, fin_vld_s, coll_s;
  logic [10:0] fin_x_s, fin_y_s, new_gx_s;
  logic [9:0]  new_gy_s;

  // Slot match on the captured read, and the ground/collision that DRAIN commits.
  always_comb begin
    dx13_s   = $signed({2'b00, dx_q});
    feet13_s = $signed({3'b000, dy_q}) + H_C;
    px13_s   = $signed({{2{cap_x_q[10]}}, cap_x_q});
    py13_s   = $signed({{2{cap_y_q[10]}}, cap_y_q});
    match_s  = cap_vld_q && cap_act_q && fall_q &&
               (py13_s <= feet13_s) && (feet13_s <= py13_s + DEPTH_C) &&
               (px13_s - XL_C <= dx13_s) && (dx13_s <= px13_s + XR_C);
    if (match_s) begin
      fin_x_s = cap_x_q;
      fin_y_s = cap_y_q;
    end else begin
      fin_x_s = pend_x_q;
      fin_y_s = pend_y_q;
    end
    fin_vld_s = pend_vld_q | match_s;
    if (fin_vld_s) begin
      new_gy_s = fin_y_s[9:0];
      new_gx_s = fin_x_s;
    end else begin
      new_gy_s = gy_q;
      new_gx_s = gx_q;
    end
    // ground_y is an unsigned screen row, so it is zero-extended for the floor test.
    gy13_s = $signed({3'b000, new_gy_s});
    gx13_s = $signed({{2{new_gx_s[10]}}, new_gx_s});
    coll_s = fall_q && (gy13_s <= feet13_s) && (feet13_s <= gy13_s + DEPTH_C) &&
             (((gx13_s - XL_C <= dx13_s) && (dx13_s <= gx13_s + XR_C)) ||
              (gy13_s >= FLOOR_C));
  end

  // Next-state and read-address sequencing.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SCAN;
          addr_d  = 7'd0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (addr_q == LAST_C) begin
          state_d = DRAIN;
          addr_d  = 7'd0;
        end else begin
          addr_d = addr_q + 7'd1;
        end
      end
      DRAIN:   state_d = RESOLVE;
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, snapshot, read pipeline and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= 7'd0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
      gy_q       <= 10'(FLOOR_Y);
      gx_q       <= 11'd0;
      dx_q       <= 11'd0;
      dy_q       <= 10'd0;
      fall_q     <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_act_q  <= 1'b0;
      cap_x_q    <= 11'd0;
      cap_y_q    <= 11'd0;
      pend_vld_q <= 1'b0;
      pend_x_q   <= 11'd0;
      pend_y_q   <= 11'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_q      <= (state_d == SCAN);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_q == DRAIN);
      cap_vld_q <= (state_q == SCAN);
      if (state_q == SCAN) begin
        cap_act_q <= plat_active;
        cap_x_q   <= plat_data[21:11];
        cap_y_q   <= plat_data[10:0];
      end
      if (state_q == IDLE && frame_start) begin
        dx_q       <= doodle_x;
        dy_q       <= doodle_y;
        fall_q     <= doodle_fall_direction;
        pend_vld_q <= 1'b0;
      end else if (match_s) begin
        pend_vld_q <= 1'b1;
        pend_x_q   <= cap_x_q;
        pend_y_q   <= cap_y_q;
      end
      if (state_q == DRAIN) begin
        gy_q   <= new_gy_s;
        gx_q   <= new_gx_s;
        coll_q <= coll_s;
      end
    end
  end

  assign plat_rd          = rd_q;
  assign plat_addr        = addr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign doodle_collision = coll_q;
  assign ground_y         = gy_q;
  assign ground_x         = gx_q;

endmodule

// File: tb/tb_platform_scan_scheduler.sv
// Bench for platform_scan_scheduler: directed and random frames against an integer
// reference model of the landing/ground/collision rules.
module tb_platform_scan_scheduler;
  localparam int N = 93;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] doodle_x = 11'd0;
  logic [9:0]  doodle_y = 10'd0;
  logic        doodle_fall_direction = 1'b0;
  logic        plat_rd;
  logic [6:0]  plat_addr;
  logic [21:0] plat_data;
  logic        plat_active;
  logic        busy, done, doodle_collision;
  logic [9:0]  ground_y;
  logic [10:0] ground_x;

  logic [10:0] tbl_x [0:127];
  logic [10:0] tbl_y [0:127];
  logic        tbl_a [0:127];

  int checks = 0;
  int errors = 0;
  int m_gy = 767;
  int m_gx = 0;
  bit m_col = 1'b0;

  platform_scan_scheduler dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .doodle_x(doodle_x), .doodle_y(doodle_y),
    .doodle_fall_direction(doodle_fall_direction),
    .plat_rd(plat_rd), .plat_addr(plat_addr),
    .plat_data(plat_data), .plat_active(plat_active),
    .busy(busy), .done(done), .doodle_collision(doodle_collision),
    .ground_y(ground_y), .ground_x(ground_x)
  );

  always #5 clk = ~clk;

  always_comb begin
    plat_data   = {tbl_x[plat_addr], tbl_y[plat_addr]};
    plat_active = tbl_a[plat_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_table();
    for (int k = 0; k < 128; k++) begin
      tbl_x[k] = 11'd0;
      tbl_y[k] = 11'd0;
      tbl_a[k] = 1'b0;
    end
  endtask

  task automatic set_slot(input int k, input int x, input int y, input bit a);
    tbl_x[k] = 11'(x);
    tbl_y[k] = 11'(y);
    tbl_a[k] = a;
  endtask

  // Reference: last matching slot becomes ground, collision tested against new ground.
  task automatic model_frame(input int dx, input int dy, input bit fall);
    int feet, px, py, hx, hy;
    bit hit;
    feet = dy + 80;
    hit  = 1'b0;
    hx   = 0;
    hy   = 0;
    for (int k = 0; k < N; k++) begin
      px = int'($signed(tbl_x[k]));
      py = int'($signed(tbl_y[k]));
      if (tbl_a[k] && fall && py <= feet && feet <= py + 30 &&
          px - 61 <= dx && dx <= px + 80) begin
        hit = 1'b1;
        hx  = px;
        hy  = py;
      end
    end
    if (hit) begin
      m_gy = hy & 1023;
      m_gx = hx;
    end
    m_col = fall && m_gy <= feet && feet <= m_gy + 30 &&
            ((m_gx - 61 <= dx && dx <= m_gx + 80) || m_gy >= 767);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_col"}, 32'(doodle_collision), 32'(m_col));
    check({tag, "_gy"},  32'(ground_y), 32'(m_gy));
    check({tag, "_gx"},  32'(ground_x), 32'(m_gx) & 32'h7FF);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_gy = 767;
    m_gx = 0;
    m_col = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int dx, input int dy, input bit fall,
                           input bit repulse);
    int early;
    model_frame(dx, dy, fall);
    @(negedge clk);
    doodle_x = 11'(dx);
    doodle_y = 10'(dy);
    doodle_fall_direction = fall;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    check({tag, "_rd0"}, 32'(plat_rd), 32'd1);
    check({tag, "_addr0"}, 32'(plat_addr), 32'd0);
    doodle_x = 11'($urandom_range(0, 2047));
    doodle_y = 10'($urandom_range(0, 1023));
    doodle_fall_direction = 1'($urandom_range(0, 1));
    early = 0;
    for (int i = 1; i <= N; i++) begin
      @(posedge clk);
      #1;
      if (done) early++;
      if (i == 40) begin
        check({tag, "_addr40"}, 32'(plat_addr), 32'd40);
        if (repulse) frame_start = 1'b1;
      end
      if (i == 41) frame_start = 1'b0;
    end
    check({tag, "_early_done"}, 32'(early), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_rd_end"}, 32'(plat_rd), 32'd0);
    check_results(tag);
    @(posedge clk);
    #1;
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int dx, dy, feet, seen;
    bit fall;
    clear_table();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd", 32'(plat_rd), 32'd0);
    check("rst_addr", 32'(plat_addr), 32'd0);
    check("rst_col", 32'(doodle_collision), 32'd0);
    check("rst_gy", 32'(ground_y), 32'd767);
    check("rst_gx", 32'(ground_x), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Empty table: floor clause lands the doodle.
    run_frame("floor", 500, 687, 1'b1, 1'b0);
    check("floor_col_exact", 32'(doodle_collision), 32'd1);

    // Single platform landing, then same geometry while rising.
    set_slot(10, 200, 400, 1'b1);
    run_frame("slot10", 250, 330, 1'b1, 1'b0);
    check("slot10_gy_exact", 32'(ground_y), 32'd400);
    check("slot10_gx_exact", 32'(ground_x), 32'd200);
    run_frame("slot10_up", 250, 330, 1'b0, 1'b0);
    check("slot10_up_col_exact", 32'(doodle_collision), 32'd0);

    // Highest-index match wins.
    clear_table();
    set_slot(5, 200, 400, 1'b1);
    set_slot(60, 200, 395, 1'b1);
    run_frame("prio", 250, 330, 1'b1, 1'b0);
    check("prio_gy_exact", 32'(ground_y), 32'd395);

    // No match on a later frame: ground retained, collision against it.
    clear_table();
    run_frame("sticky", 250, 330, 1'b1, 1'b0);

    // Window boundaries, each from reset so a match is visible as a ground change.
    clear_table();
    set_slot(20, 200, 400, 1'b1);
    for (int t = 0; t < 8; t++) begin
      case (t)
        0: begin dy = 320; dx = 200; end
        1: begin dy = 350; dx = 200; end
        2: begin dy = 319; dx = 200; end
        3: begin dy = 351; dx = 200; end
        4: begin dy = 330; dx = 139; end
        5: begin dy = 330; dx = 280; end
        6: begin dy = 330; dx = 138; end
        default: begin dy = 330; dx = 281; end
      endcase
      do_reset();
      run_frame($sformatf("edge%0d", t), dx, dy, 1'b1, 1'b0);
      check($sformatf("edge%0d_exp", t), 32'(ground_y), (t == 2 || t == 3 || t >= 6) ? 32'd767 : 32'd400);
    end
    clear_table();
    set_slot(30, -20, 400, 1'b1);
    do_reset();
    run_frame("negx", 0, 330, 1'b1, 1'b0);
    check("negx_gx_exact", 32'(ground_x), 32'h7EC);

    // Re-pulse mid-scan is ignored: no second scan follows.
    run_frame("repulse", 0, 330, 1'b1, 1'b1);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("repulse_no_second", 32'(seen), 32'd0);

    // Reset mid-scan aborts.
    @(negedge clk);
    doodle_x = 11'd0;
    doodle_y = 10'd330;
    doodle_fall_direction = 1'b1;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_gy = 767;
    m_gx = 0;
    m_col = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rd", 32'(plat_rd), 32'd0);
    check_results("abort");
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Random frames with platforms clustered around the landing window.
    for (int f = 0; f < 8; f++) begin
      dx = $urandom_range(0, 900);
      dy = $urandom_range(0, 900);
      fall = ($urandom_range(0, 4) != 0);
      feet = dy + 80;
      clear_table();
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 2) == 0)
          set_slot(k, dx - 82 + int'($urandom_range(0, 145)),
                   feet + 2 - int'($urandom_range(0, 34)), ($urandom_range(0, 3) != 0));
        else
          set_slot(k, int'($urandom_range(0, 2047)) - 1024,
                   int'($urandom_range(0, 2047)) - 1024, ($urandom_range(0, 1) != 0));
      end
      run_frame($sformatf("rand%0d", f), dx, dy, fall, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
